// File: rtl/diag_func_seq_pkg.sv
// Shared ebox types and constants for the front-end diagnostic function sequencer.
// Also holds the function-class decode used by the sequencer and its benches.
package diag_func_seq_pkg;

    typedef enum logic [1:0] {
        READ,
        LOAD,
        CTL
    } diagFuncClass_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } diagSeqState_t;

    localparam logic [6:0] DIAG_FUNC_LD_076 = 7'o076;
    localparam logic [6:0] DIAG_READ_BASE   = 7'o100;

    // Vector bit 6 is ds[0] (the MSB in EBUS numbering): 1xx reads, 04x-07x loads.
    function automatic diagFuncClass_t classify_func(input logic [6:0] func);
        if (func[6])
            return READ;
        else if (func[5])
            return LOAD;
        else
            return CTL;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/diag_func_seq.sv
// Turns single front-end diagnostic requests into a timed EBUS diagnostic cycle:
// setup, strobe and hold phases with ds/data stable around both strobe edges.
module diag_func_seq
    import diag_func_seq_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_func,
    input  logic [35:0] req_data,
    output logic        rsp_valid,
    output logic [35:0] rsp_data,
    output logic [6:0]  ebus_ds,
    output logic        ebus_diag_strobe,
    output logic [35:0] ebus_data_out,
    output logic        ebus_data_drive,
    input  logic [35:0] ebus_data_in,
    input  logic        abort,
    output logic        busy
);

    localparam int CNT_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_param_check
        $error("diag_func_seq: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
    end

    diagSeqState_t  state;
    diagFuncClass_t class_q;
    logic [CNT_W-1:0] count;

    // One down-counter is shared by all timed phases; a phase ends when it reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            class_q          <= CTL;
            count            <= '0;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            ebus_ds          <= '0;
            ebus_diag_strobe <= 1'b0;
            ebus_data_out    <= '0;
            ebus_data_drive  <= 1'b0;
            busy             <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= SETUP;
                        count     <= SETUP_LD;
                        class_q   <= classify_func(req_func);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        ebus_ds   <= req_func;
                        if (classify_func(req_func) == LOAD) begin
                            ebus_data_drive <= 1'b1;
                            ebus_data_out   <= req_data;
                        end
                    end
                end
                SETUP: begin
                    if (abort) begin
                        state <= HOLD;
                        count <= HOLD_LD;
                    end else if (count == CNT_ONE) begin
                        state            <= STROBE;
                        count            <= STROBE_LD;
                        ebus_diag_strobe <= 1'b1;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                STROBE: begin
                    // An aborted strobe still gets a full hold, but reports nothing.
                    if (abort) begin
                        state            <= HOLD;
                        count            <= HOLD_LD;
                        ebus_diag_strobe <= 1'b0;
                    end else if (count == CNT_ONE) begin
                        state            <= HOLD;
                        count            <= HOLD_LD;
                        ebus_diag_strobe <= 1'b0;
                        rsp_valid        <= 1'b1;
                        rsp_data         <= (class_q == READ) ? ebus_data_in : '0;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (count == CNT_ONE) begin
                        state           <= GAP;
                        ebus_ds         <= '0;
                        ebus_data_drive <= 1'b0;
                        ebus_data_out   <= '0;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                GAP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state            <= IDLE;
                    req_ready        <= 1'b1;
                    busy             <= 1'b0;
                    ebus_ds          <= '0;
                    ebus_diag_strobe <= 1'b0;
                    ebus_data_out    <= '0;
                    ebus_data_drive  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_func_seq.sv
// Directed bench for diag_func_seq: per-cycle timeline checks against the
// documented latency plus a scoreboard of expected responses.
module tb_diag_func_seq;
    import diag_func_seq_pkg::*;

    localparam int S = 2;
    localparam int T = 4;
    localparam int H = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_func;
    logic [35:0] req_data;
    logic        rsp_valid;
    logic [35:0] rsp_data;
    logic [6:0]  ebus_ds;
    logic        ebus_diag_strobe;
    logic [35:0] ebus_data_out;
    logic        ebus_data_drive;
    logic [35:0] ebus_data_in;
    logic        abort;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [35:0] sb[$];

    diag_func_seq #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_func(req_func),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .ebus_ds(ebus_ds),
        .ebus_diag_strobe(ebus_diag_strobe),
        .ebus_data_out(ebus_data_out),
        .ebus_data_drive(ebus_data_drive),
        .ebus_data_in(ebus_data_in),
        .abort(abort),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0o expected=%0o", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every response pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0)
                checkOutput("rsp_valid unexpected", {35'd0, rsp_valid}, 36'd0);
            else
                checkOutput("rsp_data scoreboard", rsp_data, sb.pop_front());
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req_ready"}, {35'd0, req_ready}, 36'd1);
        checkOutput({tag, " rsp_valid"}, {35'd0, rsp_valid}, 36'd0);
        checkOutput({tag, " rsp_data"}, rsp_data, 36'd0);
        checkOutput({tag, " ebus_ds"}, {29'd0, ebus_ds}, 36'd0);
        checkOutput({tag, " strobe"}, {35'd0, ebus_diag_strobe}, 36'd0);
        checkOutput({tag, " data_out"}, ebus_data_out, 36'd0);
        checkOutput({tag, " data_drive"}, {35'd0, ebus_data_drive}, 36'd0);
        checkOutput({tag, " busy"}, {35'd0, busy}, 36'd0);
    endtask

    // Expected outputs at cycle k after an accept at cycle 0 (abort_at=0: no abort).
    task automatic checkCycle(input string name, input int k, input logic [6:0] func,
                              input bit is_load, input logic [35:0] data, input int abort_at);
        int  last_drive;
        bit  drv;
        last_drive = (abort_at > 0) ? abort_at + H : S + T + H;
        drv = is_load && k >= 1 && k <= last_drive;
        checkOutput($sformatf("%s ds c%0d", name, k), {29'd0, ebus_ds},
                    (k >= 1 && k <= last_drive) ? {29'd0, func} : 36'd0);
        checkOutput($sformatf("%s strobe c%0d", name, k), {35'd0, ebus_diag_strobe},
                    {35'd0, (k >= S + 1 && k <= S + T && (abort_at == 0 || k <= abort_at))});
        checkOutput($sformatf("%s drive c%0d", name, k), {35'd0, ebus_data_drive}, {35'd0, drv});
        if (drv)
            checkOutput($sformatf("%s data_out c%0d", name, k), ebus_data_out, data);
        checkOutput($sformatf("%s ready c%0d", name, k), {35'd0, req_ready},
                    {35'd0, (k > last_drive + 1)});
        checkOutput($sformatf("%s busy c%0d", name, k), {35'd0, busy},
                    {35'd0, (k >= 1 && k <= last_drive + 1)});
        checkOutput($sformatf("%s rsp_valid c%0d", name, k), {35'd0, rsp_valid},
                    {35'd0, (abort_at == 0 && k == S + T + 1)});
    endtask

    task automatic applyStimulus(input logic [6:0] func, input logic [35:0] data,
                                 input bit expect_rsp, input logic [35:0] rsp);
        checkOutput($sformatf("accept ready func=%0o", func), {35'd0, req_ready}, 36'd1);
        req_valid = 1'b1;
        req_func  = func;
        req_data  = data;
        if (expect_rsp)
            sb.push_back(rsp);
    endtask

    task automatic runCycles(input string name, input logic [6:0] func, input bit is_load,
                             input logic [35:0] data, input int abort_at, input int ncycles);
        for (int k = 1; k <= ncycles; k++) begin
            step();
            if (k == 1)
                req_valid = 1'b0;
            abort = (k == abort_at);
            checkCycle(name, k, func, is_load, data, abort_at);
        end
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_func     = '0;
        req_data     = '0;
        ebus_data_in = '0;
        abort        = 1'b0;
        step();
        step();
        checkResetValues("reset");
        reset = 1'b0;
        step();

        $display("[TB] read 100");
        ebus_data_in = 36'o123456701234;
        applyStimulus(DIAG_READ_BASE, 36'o777777777777, 1'b1, 36'o123456701234);
        runCycles("read", DIAG_READ_BASE, 1'b0, '0, 0, 10);

        $display("[TB] load 076");
        applyStimulus(DIAG_FUNC_LD_076, 36'h000000A00, 1'b1, 36'd0);
        runCycles("load", DIAG_FUNC_LD_076, 1'b1, 36'h000000A00, 0, 10);

        // Same read held valid; the sample must come from the last strobe cycle each time.
        $display("[TB] back-to-back reads");
        ebus_data_in = 36'o111111111111;
        applyStimulus(7'o102, '0, 1'b1, 36'o111111111111);
        sb.push_back(36'o222222222222);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 8)
                ebus_data_in = 36'o222222222222;
            if (k == 11)
                req_valid = 1'b0;
            if (k <= 10)
                checkCycle("b2b first", k, 7'o102, 1'b0, '0, 0);
            else
                checkCycle("b2b second", k - 10, 7'o102, 1'b0, '0, 0);
        end

        $display("[TB] abort during strobe");
        ebus_data_in = 36'o555555555555;
        applyStimulus(7'o104, '0, 1'b0, '0);
        runCycles("abort", 7'o104, 1'b0, '0, 4, 8);

        $display("[TB] reset mid-cycle");
        applyStimulus(DIAG_FUNC_LD_076, 36'o777000111222, 1'b0, '0);
        runCycles("midreset", DIAG_FUNC_LD_076, 1'b1, 36'o777000111222, 0, 4);
        reset = 1'b1;
        step();
        checkResetValues("midreset c5");
        reset = 1'b0;
        step();
        checkOutput("midreset c6 ready", {35'd0, req_ready}, 36'd1);

        $display("[TB] ctl 001 with abort in idle");
        abort = 1'b1;
        applyStimulus(7'o001, 36'o123123123123, 1'b1, 36'd0);
        runCycles("ctl", 7'o001, 1'b0, '0, 0, 10);

        $display("[TB] func 000");
        applyStimulus(7'o000, 36'o444444444444, 1'b1, 36'd0);
        runCycles("f000", 7'o000, 1'b0, '0, 0, 10);

        step();
        checkOutput("scoreboard drained", 36'(sb.size()), 36'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/diag_func_seq.md
Name: diag_func_seq

Overview:
- Upstream neighbour of the EBOX CTL diagnostic decode.
- Turns single front-end diagnostic requests (function code plus data) into a correctly timed EBUS diagnostic cycle. It drives `ebus_ds[0:6]` and `ebus_diag_strobe`, and drives the data bus for load functions.
- For read functions (1xx) it samples `ebus_data_in[0:35]` and returns the value.
- Sits between the front-end/DTE model and the EBUS, so CTL sees stable `ds` before and after every strobe edge.

Parameters:
- SETUP_CYC, 2, cycles `ds`/data are stable before strobe rises (≥1)
- STROBE_CYC, 4, cycles strobe is held high (≥1)
- HOLD_CYC, 2, cycles `ds`/data are held after strobe falls (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  front-end request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_func  in  7  diagnostic function code, bit 0 MSB (`ds[0:6]`)
- req_data  in  36  data for load functions, bit 0 MSB
- rsp_valid  out  1  one-cycle pulse: cycle complete
- rsp_data  out  36  sampled EBUS data (reads); 0 for non-reads
- ebus_ds  out  7  diagnostic select to EBUS
- ebus_diag_strobe  out  1  diagnostic strobe to EBUS
- ebus_data_out  out  36  data driven onto EBUS
- ebus_data_drive  out  1  `ebus_data_out` is valid/driven
- ebus_data_in  in  36  EBUS data as seen by sequencer
- abort  in  1  terminate current cycle early
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `ebus_ds`=0, `ebus_diag_strobe`=0, `ebus_data_out`=0, `ebus_data_drive`=0, `busy`=0. All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, GAP. A single down-counter is sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
- IDLE: `req_ready`=1. On `req_valid` the sequencer latches func/data, classifies the request and enters SETUP with count=SETUP_CYC.
  - Read class: func[0]=1.
  - Load class: func[0:1]=01 (04x–07x).
  - Control class: all other codes.
- SETUP: `ebus_ds`=latched func. For load class, `ebus_data_drive`=1 and `ebus_data_out`=latched data. After SETUP_CYC cycles, enter STROBE.
- STROBE: `ebus_diag_strobe`=1 for exactly STROBE_CYC cycles. For read class, `ebus_data_in` is sampled on the last STROBE cycle. Then enter HOLD.
- HOLD: strobe=0; `ds` and data are still driven. `rsp_valid` pulses in the first HOLD cycle, with `rsp_data` = sample for reads, otherwise 0. After HOLD_CYC cycles, enter GAP.
- GAP: one cycle with `ds`=0 and `data_drive`=0, so CTL.CONSOLE_CONTROL drops between requests. Then enter IDLE.
- Latency: for an accept at cycle 0:
  - SETUP occupies cycles 1..S.
  - Strobe is high at cycles S+1..S+T.
  - `rsp_valid` pulses at S+T+1.
  - GAP is at S+T+H+1.
  - `req_ready` rises at S+T+H+2.
- `req_ready`=0 whenever not IDLE. Requests that arrive then are not latched, and the requester must hold them.
- Abort:
  - In SETUP or STROBE: strobe drops next cycle and the FSM goes to HOLD with count=HOLD_CYC. No `rsp_valid` and no read sample.
  - In HOLD, GAP or IDLE: ignored.
- Abort and `req_valid` together in IDLE: the request is accepted; abort applies only to active cycles.
- Reset mid-cycle: next cycle all outputs take reset values, with no `rsp_valid` and no GAP.
- Func 000 is legal and runs a full cycle, but `ebus_ds` stays 0 throughout.
- Parameter check: an elaboration-time assertion requires all three parameters ≥1.

Decomposition:
- Shared ebox package additions: `diagFuncClass_t` enum (READ, LOAD, CTL); `diagSeqState_t` enum; constants `DIAG_FUNC_LD_076`=7'o076 and `DIAG_READ_BASE`=7'o100 for benches.
- No sub-module; the counter and FSM live in one module.

Test Plan:
- Read 7'o100 with `ebus_data_in`=36'o123456_701234 held, defaults → strobe high cycles 3–6, `rsp_valid` at 7 with `rsp_data`=36'o123456701234, `ds`=7'o100 for cycles 1–8, `ds`=0 at 9, `req_ready`=1 at 10.
- Load 7'o076 with data bits 24–27=1010 → `ebus_data_drive`=1 and `data_out` stable cycles 1–8; CTL latches MEM_RESET=1 and LD_EBUS_REG=1 at strobe edge.
- Back-to-back requests held valid → second accepted at cycle 10; GAP cycle 9 shows `ds`=0; strobe never high two cycles apart.
- Abort at cycle 4 of a read → strobe low at 5, HOLD cycles 5–6, GAP 7, no `rsp_valid`.
- Reset at cycle 4 → cycle 5 all outputs 0, `req_ready`=1; new request then completes normally.
- Ctl func 7'o001 → `data_drive` never 1, `rsp_valid` with `rsp_data`=0.
